// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction fetch queue.
// The slave modport is the queue itself; the master modport is the
// fetch/decode side that drives packs and consumes issued lanes.
interface fetch_queue_if #(
  parameter int PTR_W = 3
);
  logic             io_i_flush;
  logic             io_i_pack_valid;
  logic             io_o_pack_ready;
  logic             io_i_pack_valids_0;
  logic             io_i_pack_valids_1;
  logic [63:0]      io_i_pack_pc;
  logic [31:0]      io_i_pack_insts_0;
  logic [31:0]      io_i_pack_insts_1;
  logic             io_i_bp_valid;
  logic             io_i_bp_taken;
  logic             io_i_bp_select;
  logic [63:0]      io_i_bp_target;
  logic [3:0]       io_i_bp_branch_type;
  logic             io_i_decode_ready;
  logic             io_o_valid_0;
  logic             io_o_valid_1;
  logic [63:0]      io_o_pc_0;
  logic [63:0]      io_o_pc_1;
  logic [31:0]      io_o_inst_0;
  logic [31:0]      io_o_inst_1;
  logic             io_o_bp_valid_0;
  logic             io_o_bp_valid_1;
  logic             io_o_bp_taken_0;
  logic             io_o_bp_taken_1;
  logic [63:0]      io_o_bp_target_0;
  logic [63:0]      io_o_bp_target_1;
  logic [3:0]       io_o_bp_branch_type_0;
  logic [3:0]       io_o_bp_branch_type_1;
  logic [PTR_W:0]   io_o_count;

  modport slave (
    input  io_i_flush, io_i_pack_valid, io_i_pack_valids_0, io_i_pack_valids_1,
           io_i_pack_pc, io_i_pack_insts_0, io_i_pack_insts_1,
           io_i_bp_valid, io_i_bp_taken, io_i_bp_select, io_i_bp_target,
           io_i_bp_branch_type, io_i_decode_ready,
    output io_o_pack_ready, io_o_valid_0, io_o_valid_1, io_o_pc_0, io_o_pc_1,
           io_o_inst_0, io_o_inst_1, io_o_bp_valid_0, io_o_bp_valid_1,
           io_o_bp_taken_0, io_o_bp_taken_1, io_o_bp_target_0, io_o_bp_target_1,
           io_o_bp_branch_type_0, io_o_bp_branch_type_1, io_o_count
  );

  modport master (
    output io_i_flush, io_i_pack_valid, io_i_pack_valids_0, io_i_pack_valids_1,
           io_i_pack_pc, io_i_pack_insts_0, io_i_pack_insts_1,
           io_i_bp_valid, io_i_bp_taken, io_i_bp_select, io_i_bp_target,
           io_i_bp_branch_type, io_i_decode_ready,
    input  io_o_pack_ready, io_o_valid_0, io_o_valid_1, io_o_pc_0, io_o_pc_1,
           io_o_inst_0, io_o_inst_1, io_o_bp_valid_0, io_o_bp_valid_1,
           io_o_bp_taken_0, io_o_bp_taken_1, io_o_bp_target_0, io_o_bp_target_1,
           io_o_bp_branch_type_0, io_o_bp_branch_type_1, io_o_count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: splits 2-wide fetch packs into per-instruction
// entries of a circular buffer and issues up to two entries per cycle, in
// program order, to decode. A redirect flush empties the queue at once.
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  fetch_queue_if.slave     io
);

  localparam logic [PTR_W:0] DEPTH_M2 = (PTR_W+1)'(DEPTH - 2);

  // Queue state
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;

  // Entry storage, not reset: only slots between head and tail are ever read
  logic [63:0] pc_mem     [DEPTH];
  logic [31:0] inst_mem   [DEPTH];
  logic        bpv_mem    [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [63:0] target_mem [DEPTH];
  logic [3:0]  btype_mem  [DEPTH];

  logic             enq_fire;
  logic [PTR_W:0]   n_enq;
  logic [PTR_W:0]   n_deq;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] slot1_idx;
  logic             bp_hit_0;
  logic             bp_hit_1;

  // Handshake, lane selection and enqueue/dequeue amounts for this cycle
  always_comb begin
    io.io_o_pack_ready = (count_q <= DEPTH_M2);
    io.io_o_valid_0    = (count_q != '0) & ~io.io_i_flush;
    io.io_o_valid_1    = (count_q >= (PTR_W+1)'(2)) & ~io.io_i_flush;
    io.io_o_count      = count_q;

    head_p1   = head_q + PTR_W'(1);
    slot1_idx = tail_q + PTR_W'(io.io_i_pack_valids_0);

    enq_fire = io.io_i_pack_valid & io.io_o_pack_ready & ~io.io_i_flush;
    n_enq    = enq_fire ? ((PTR_W+1)'(io.io_i_pack_valids_0) + (PTR_W+1)'(io.io_i_pack_valids_1))
                        : '0;
    n_deq    = io.io_i_decode_ready ? ((PTR_W+1)'(io.io_o_valid_0) + (PTR_W+1)'(io.io_o_valid_1))
                                    : '0;

    bp_hit_0 = io.io_i_bp_valid & ~io.io_i_bp_select;
    bp_hit_1 = io.io_i_bp_valid &  io.io_i_bp_select;

    io.io_o_pc_0             = pc_mem[head_q];
    io.io_o_inst_0           = inst_mem[head_q];
    io.io_o_bp_valid_0       = bpv_mem[head_q];
    io.io_o_bp_taken_0       = taken_mem[head_q];
    io.io_o_bp_target_0      = target_mem[head_q];
    io.io_o_bp_branch_type_0 = btype_mem[head_q];

    io.io_o_pc_1             = pc_mem[head_p1];
    io.io_o_inst_1           = inst_mem[head_p1];
    io.io_o_bp_valid_1       = bpv_mem[head_p1];
    io.io_o_bp_taken_1       = taken_mem[head_p1];
    io.io_o_bp_target_1      = target_mem[head_p1];
    io.io_o_bp_branch_type_1 = btype_mem[head_p1];
  end

  // Write live slots compacted at tail; predict info sticks only to the selected slot
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      if (io.io_i_pack_valids_0) begin
        pc_mem[tail_q]     <= io.io_i_pack_pc;
        inst_mem[tail_q]   <= io.io_i_pack_insts_0;
        bpv_mem[tail_q]    <= bp_hit_0;
        taken_mem[tail_q]  <= bp_hit_0 & io.io_i_bp_taken;
        target_mem[tail_q] <= bp_hit_0 ? io.io_i_bp_target : 64'd0;
        btype_mem[tail_q]  <= bp_hit_0 ? io.io_i_bp_branch_type : 4'd0;
      end
      if (io.io_i_pack_valids_1) begin
        pc_mem[slot1_idx]     <= io.io_i_pack_pc + 64'd4;
        inst_mem[slot1_idx]   <= io.io_i_pack_insts_1;
        bpv_mem[slot1_idx]    <= bp_hit_1;
        taken_mem[slot1_idx]  <= bp_hit_1 & io.io_i_bp_taken;
        target_mem[slot1_idx] <= bp_hit_1 ? io.io_i_bp_target : 64'd0;
        btype_mem[slot1_idx]  <= bp_hit_1 ? io.io_i_bp_branch_type : 4'd0;
      end
    end
  end

  // Pointer and occupancy update; flush wins over any enqueue/dequeue
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (io.io_i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + n_deq[PTR_W-1:0];
      tail_q  <= tail_q + n_enq[PTR_W-1:0];
      count_q <= count_q + n_enq - n_deq;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the driver pushes expected entries as
// packs are accepted, and a negedge monitor compares the issued lanes.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        bpv;
    logic        taken;
    logic [63:0] target;
    logic [3:0]  btype;
  } entry_t;

  typedef struct {
    logic        pv;
    logic        v0;
    logic        v1;
    logic [63:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        bpv;
    logic        bpt;
    logic        bps;
    logic [63:0] tgt;
    logic [3:0]  bty;
    logic        dr;
    logic        fl;
  } stim_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  entry_t exp_q[$];
  entry_t pending_q[$];

  fetch_queue_if #(.PTR_W(PTR_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  // 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic stim_t idle(input logic dr);
    stim_t s;
    s = '{pv: 1'b0, v0: 1'b0, v1: 1'b0, pc: 64'd0, i0: 32'd0, i1: 32'd0, bpv: 1'b0,
          bpt: 1'b0, bps: 1'b0, tgt: 64'd0, bty: 4'd0, dr: dr, fl: 1'b0};
    return s;
  endfunction

  function automatic stim_t pack(input logic [63:0] pc, input logic v0, input logic v1,
                                 input logic dr);
    stim_t s;
    s = idle(dr);
    s.pv = 1'b1;
    s.v0 = v0;
    s.v1 = v1;
    s.pc = pc;
    s.i0 = $urandom;
    s.i1 = $urandom;
    return s;
  endfunction

  function automatic entry_t make_entry(input stim_t s, input int slot);
    entry_t e;
    logic   hit;
    hit      = s.bpv && (int'(s.bps) == slot);
    e.pc     = s.pc + 64'(4 * slot);
    e.inst   = (slot == 0) ? s.i0 : s.i1;
    e.bpv    = hit;
    e.taken  = hit ? s.bpt : 1'b0;
    e.target = hit ? s.tgt : 64'd0;
    e.btype  = hit ? s.bty : 4'd0;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus.io_i_pack_valid     = s.pv;
    bus.io_i_pack_valids_0  = s.v0;
    bus.io_i_pack_valids_1  = s.v1;
    bus.io_i_pack_pc        = s.pc;
    bus.io_i_pack_insts_0   = s.i0;
    bus.io_i_pack_insts_1   = s.i1;
    bus.io_i_bp_valid       = s.bpv;
    bus.io_i_bp_taken       = s.bpt;
    bus.io_i_bp_select      = s.bps;
    bus.io_i_bp_target      = s.tgt;
    bus.io_i_bp_branch_type = s.bty;
    bus.io_i_decode_ready   = s.dr;
    bus.io_i_flush          = s.fl;
  endtask

  // One cycle: commit last cycle's accepted entries, then present new stimulus
  task automatic apply_stimulus(input stim_t s);
    @(posedge clock);
    foreach (pending_q[k]) exp_q.push_back(pending_q[k]);
    pending_q.delete();
    #1;
    drive(s);
    if (s.pv && !s.fl && exp_q.size() <= DEPTH - 2) begin
      if (s.v0) pending_q.push_back(make_entry(s, 0));
      if (s.v1) pending_q.push_back(make_entry(s, 1));
    end
  endtask

  task automatic compare_lane(input int lane, input entry_t e);
    if (lane == 0) begin
      check_output("lane0_pc", bus.io_o_pc_0, e.pc);
      check_output("lane0_inst", 64'(bus.io_o_inst_0), 64'(e.inst));
      check_output("lane0_bp_valid", 64'(bus.io_o_bp_valid_0), 64'(e.bpv));
      check_output("lane0_bp_taken", 64'(bus.io_o_bp_taken_0), 64'(e.taken));
      check_output("lane0_bp_target", bus.io_o_bp_target_0, e.target);
      check_output("lane0_bp_type", 64'(bus.io_o_bp_branch_type_0), 64'(e.btype));
    end else begin
      check_output("lane1_pc", bus.io_o_pc_1, e.pc);
      check_output("lane1_inst", 64'(bus.io_o_inst_1), 64'(e.inst));
      check_output("lane1_bp_valid", 64'(bus.io_o_bp_valid_1), 64'(e.bpv));
      check_output("lane1_bp_taken", 64'(bus.io_o_bp_taken_1), 64'(e.taken));
      check_output("lane1_bp_target", bus.io_o_bp_target_1, e.target);
      check_output("lane1_bp_type", 64'(bus.io_o_bp_branch_type_1), 64'(e.btype));
    end
  endtask

  // Monitor: mid-cycle comparison of lanes and occupancy against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        int  n;
        logic fl;
        n  = exp_q.size();
        fl = bus.io_i_flush;
        check_output("count", 64'(bus.io_o_count), 64'(n));
        check_output("pack_ready", 64'(bus.io_o_pack_ready), 64'(n <= DEPTH - 2));
        check_output("valid_0", 64'(bus.io_o_valid_0), 64'(!fl && n >= 1));
        check_output("valid_1", 64'(bus.io_o_valid_1), 64'(!fl && n >= 2));
        if (!fl && n >= 1) compare_lane(0, exp_q[0]);
        if (!fl && n >= 2) compare_lane(1, exp_q[1]);
        if (fl) begin
          exp_q.delete();
        end else if (bus.io_i_decode_ready) begin
          for (int k = 0; k < 2; k++) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check_output({tag, "_valid_0"}, 64'(bus.io_o_valid_0), 64'd0);
    check_output({tag, "_valid_1"}, 64'(bus.io_o_valid_1), 64'd0);
    check_output({tag, "_pack_ready"}, 64'(bus.io_o_pack_ready), 64'd1);
    check_output({tag, "_count"}, 64'(bus.io_o_count), 64'd0);
  endtask

  initial begin
    stim_t s;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(idle(1'b0));
    repeat (2) @(posedge clock);
    #1;
    check_reset_state("reset");
    @(posedge clock);
    #3 reset = 1'b0;

    // Full pack taken straight through by decode
    s = pack(64'h8000_0000, 1'b1, 1'b1, 1'b1);
    s.i0 = 32'hAAAA_0001;
    s.i1 = 32'hBBBB_0002;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle(1'b1));

    // Only slot 1 live: entry pc is base + 4
    apply_stimulus(pack(64'h1000, 1'b0, 1'b1, 1'b0));
    apply_stimulus(idle(1'b0));
    apply_stimulus(idle(1'b1));

    // Predict info attaches only to the selected slot
    s = pack(64'h3000, 1'b1, 1'b1, 1'b0);
    s.bpv = 1'b1; s.bpt = 1'b1; s.bps = 1'b0; s.tgt = 64'h2000; s.bty = 4'h5;
    apply_stimulus(s);
    s = pack(64'h3008, 1'b1, 1'b1, 1'b0);
    s.bpv = 1'b1; s.bpt = 1'b1; s.bps = 1'b1; s.tgt = 64'h4440; s.bty = 4'h9;
    apply_stimulus(s);
    repeat (3) apply_stimulus(idle(1'b1));

    // Fill to full with decode stalled, then drain across the wrap
    for (int p = 0; p < 5; p++) apply_stimulus(pack(64'h5000 + 64'(8 * p), 1'b1, 1'b1, 1'b0));
    repeat (5) apply_stimulus(idle(1'b1));

    // Hold at 6 with simultaneous enqueue and dequeue, then flush with a pack present
    for (int p = 0; p < 3; p++) apply_stimulus(pack(64'h6000 + 64'(8 * p), 1'b1, 1'b1, 1'b0));
    for (int p = 0; p < 3; p++) apply_stimulus(pack(64'h7000 + 64'(8 * p), 1'b1, 1'b1, 1'b1));
    s = pack(64'h9000, 1'b1, 1'b1, 1'b1);
    s.fl = 1'b1;
    apply_stimulus(s);
    repeat (2) apply_stimulus(idle(1'b1));

    // Randomized traffic
    for (int c = 0; c < 800; c++) begin
      s = pack({$urandom, $urandom} & ~64'h7, 1'($urandom), 1'($urandom), 1'($urandom));
      s.pv  = ($urandom_range(0, 3) != 0);
      s.bpv = 1'($urandom);
      s.bpt = 1'($urandom);
      s.bps = 1'($urandom);
      s.tgt = {$urandom, $urandom};
      s.bty = 4'($urandom);
      s.fl  = ($urandom_range(0, 31) == 0);
      apply_stimulus(s);
    end

    // Asynchronous reset in the middle of traffic
    for (int p = 0; p < 3; p++) apply_stimulus(pack(64'hA000 + 64'(8 * p), 1'b1, 1'b1, 1'b0));
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    drive(idle(1'b1));
    pending_q.delete();
    exp_q.delete();
    @(posedge clock);
    #3 reset = 1'b0;
    for (int p = 0; p < 4; p++) apply_stimulus(pack(64'hB000 + 64'(8 * p), 1'b1, 1'b1, 1'b1));
    repeat (4) apply_stimulus(idle(1'b1));
    @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
